// File: rtl/memblk_pkg.sv
// Shared memblk geometry, request typedef, port FSM states and address packing helpers.
package memblk_pkg;

    localparam int MB_ADDR_W = 39;
    localparam int MB_DATA_W = 533;
    localparam int MB_LAT    = 48;
    localparam int MB_TAG_W  = 4;
    localparam int MB_LINE_W = 33;

    typedef struct packed {
        logic                 own;
        logic [MB_LINE_W-1:0] addr;
        logic [MB_TAG_W-1:0]  tag;
    } mb_req_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } port_state_t;

    // Read address carries the ownership hint in bit 37.
    function automatic logic [MB_ADDR_W-1:0] mb_rd_addr(input mb_req_t r);
        return {1'b0, r.own, r.addr, r.tag};
    endfunction

    function automatic logic [MB_ADDR_W-1:0] mb_wr_addr(input mb_req_t r);
        return {2'b00, r.addr, r.tag};
    endfunction

endpackage

// File: rtl/mem_req_port_chk.sv
// Protocol checks for mem_req_port: read returns line up with the shadow pipe and the FIFO never overflows.
module mem_req_port_chk (
    input logic clk,
    input logic rst,
    input logic capture,
    input logic rden_out,
    input logic fifo_full,
    input logic fifo_pop
);
    // Sampled every edge outside reset.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!capture || rden_out)
                else $error("mem_req_port: memblk read return missing at capture");
            assert (!(capture && fifo_full && !fifo_pop))
                else $error("mem_req_port: response FIFO overflow");
        end
    end

endmodule

// File: rtl/mem_rsp_fifo.sv
// Response FIFO for mem_req_port: DEPTH entries (power of 2), same-cycle push and pop allowed even when full.
module mem_rsp_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               pop_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign empty     = (count_r == CW'(0));
    assign full      = (count_r == CW'(DEPTH));
    assign count     = count_r;
    assign pop_data  = mem_r[rd_ptr_r];
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= CW'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/mem_req_port.sv
// Load/store initiator for one memblk port with credited read responses and flush handshake.
// Optional MEM_REQ_PERF_CNT_EN adds perf_ld/perf_st/perf_stall event counters.
module mem_req_port
    import memblk_pkg::*;
#(
    parameter int LAT       = MB_LAT,
    parameter int RSP_DEPTH = 8,
    parameter int ADDR_W    = MB_ADDR_W,
    parameter int DATA_W    = MB_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic                req_own,
    input  logic [32:0]         req_addr,
    input  logic [3:0]          req_tag,
    input  logic [DATA_W-1:0]   req_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [3:0]          rsp_tag,
    output logic [DATA_W-1:0]   rsp_data,
    input  logic                flush_req,
    output logic                flush_ack,
    input  logic                mb_stall,
    output logic [ADDR_W-1:0]   mb_rdaddr0,
    output logic                mb_rden,
    output logic [ADDR_W-1:0]   mb_wraddr0,
    output logic [DATA_W-1:0]   mb_wrdata,
    output logic                mb_wren,
    input  logic [DATA_W-1:0]   mb_rddata,
    input  logic                mb_rden_out
`ifdef MEM_REQ_PERF_CNT_EN
    ,
    output logic [31:0]         perf_ld,
    output logic [31:0]         perf_st,
    output logic [31:0]         perf_stall
`endif
);
    localparam int CNT_W = $clog2(RSP_DEPTH) + 1;
    localparam int IF_W  = $clog2(LAT + 1);
    localparam int SUM_W = ((IF_W > CNT_W) ? IF_W : CNT_W) + 1;
    localparam int ENT_W = MB_TAG_W + DATA_W;

    port_state_t         state_r;
    logic                flush_ack_r;
    logic [LAT-1:0]      shadow_vld_r;
    logic [MB_TAG_W-1:0] shadow_tag_r [LAT];
    logic [IF_W-1:0]     inflight_r;
    logic [CNT_W-1:0]    fifo_count_s;
    logic                fifo_empty_s;
    logic                fifo_full_s;
    logic [ENT_W-1:0]    fifo_out_s;
    logic [SUM_W-1:0]    used_s;
    logic                credit_ok_s;
    logic                fire_s;
    logic                ld_fire_s;
    logic                capture_s;
    logic                pop_s;
    mb_req_t             req_s;

    // A load needs a credit: every in-flight read must already own a FIFO slot.
    assign req_s       = '{own: req_own, addr: req_addr, tag: req_tag};
    assign used_s      = SUM_W'(inflight_r) + SUM_W'(fifo_count_s);
    assign credit_ok_s = (used_s < SUM_W'(RSP_DEPTH));
    assign req_ready   = ~rst & (state_r == ST_RUN) & ~mb_stall & (req_we | credit_ok_s);
    assign fire_s      = req_valid & req_ready;
    assign ld_fire_s   = fire_s & ~req_we;

    assign mb_rden    = ld_fire_s;
    assign mb_wren    = fire_s & req_we;
    assign mb_rdaddr0 = mb_rd_addr(req_s);
    assign mb_wraddr0 = mb_wr_addr(req_s);
    assign mb_wrdata  = req_data;

    assign capture_s = ~mb_stall & shadow_vld_r[LAT-1];
    assign rsp_valid = ~fifo_empty_s;
    assign pop_s     = rsp_valid & rsp_ready;
    assign rsp_tag   = fifo_out_s[ENT_W-1 -: MB_TAG_W];
    assign rsp_data  = fifo_out_s[DATA_W-1:0];
    assign flush_ack = flush_ack_r;

    // Shadow of the memblk read pipeline; frozen whenever memblk stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_vld_r <= {LAT{1'b0}};
            for (int i = 0; i < LAT; i++) begin
                shadow_tag_r[i] <= {MB_TAG_W{1'b0}};
            end
        end else if (!mb_stall) begin
            shadow_vld_r    <= {shadow_vld_r[LAT-2:0], ld_fire_s};
            shadow_tag_r[0] <= req_tag;
            for (int i = 1; i < LAT; i++) begin
                shadow_tag_r[i] <= shadow_tag_r[i-1];
            end
        end else begin
            shadow_vld_r <= shadow_vld_r;
        end
    end

    // Count of loads issued but not yet captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_r <= IF_W'(0);
        end else begin
            case ({ld_fire_s, capture_s})
                2'b10:   inflight_r <= inflight_r + IF_W'(1);
                2'b01:   inflight_r <= inflight_r - IF_W'(1);
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    // Flush handshake: block issue, wait for empty, pulse ack for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_RUN;
            flush_ack_r <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    flush_ack_r <= 1'b0;
                    state_r     <= flush_req ? ST_DRAIN : ST_RUN;
                end
                ST_DRAIN: begin
                    if ((inflight_r == IF_W'(0)) && fifo_empty_s) begin
                        state_r     <= ST_DONE;
                        flush_ack_r <= 1'b1;
                    end else begin
                        state_r     <= ST_DRAIN;
                        flush_ack_r <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_r     <= ST_RUN;
                    flush_ack_r <= 1'b0;
                end
                default: begin
                    state_r     <= ST_RUN;
                    flush_ack_r <= 1'b0;
                end
            endcase
        end
    end

    mem_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .W     (ENT_W)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (capture_s),
        .push_data ({shadow_tag_r[LAT-1], mb_rddata}),
        .pop       (pop_s),
        .pop_data  (fifo_out_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s),
        .count     (fifo_count_s)
    );

    mem_req_port_chk u_chk (
        .clk       (clk),
        .rst       (rst),
        .capture   (capture_s),
        .rden_out  (mb_rden_out),
        .fifo_full (fifo_full_s),
        .fifo_pop  (pop_s)
    );

`ifdef MEM_REQ_PERF_CNT_EN
    // Event counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ld    <= 32'd0;
            perf_st    <= 32'd0;
            perf_stall <= 32'd0;
        end else begin
            perf_ld    <= perf_ld + {31'd0, ld_fire_s};
            perf_st    <= perf_st + {31'd0, mb_wren};
            perf_stall <= perf_stall + {31'd0, req_valid & mb_stall};
        end
    end
`endif

endmodule

// File: tb/tb_mem_req_port.sv
// Directed bench for mem_req_port: memblk behavioural model plus a response scoreboard.
module tb_mem_req_port;
    import memblk_pkg::*;

    localparam int LAT    = MB_LAT;
    localparam int ADDR_W = MB_ADDR_W;
    localparam int DATA_W = MB_DATA_W;
    localparam int CHK_W  = DATA_W + 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_we, req_own;
    logic [32:0]       req_addr;
    logic [3:0]        req_tag;
    logic [DATA_W-1:0] req_data;
    logic              rsp_valid, rsp_ready;
    logic [3:0]        rsp_tag;
    logic [DATA_W-1:0] rsp_data;
    logic              flush_req, flush_ack, mb_stall;
    logic [ADDR_W-1:0] mb_rdaddr0, mb_wraddr0;
    logic              mb_rden, mb_wren;
    logic [DATA_W-1:0] mb_wrdata;
    logic [DATA_W-1:0] mb_rddata = '0;
    logic              mb_rden_out = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rsp_cnt = 0;

    typedef struct packed {
        logic [3:0]        tag;
        logic [DATA_W-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        int                ns;
        logic [ADDR_W-1:0] addr;
    } mb_ent_t;
    mb_ent_t mb_q[$];

    mem_req_port dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_own(req_own),
        .req_addr(req_addr), .req_tag(req_tag), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
        .flush_req(flush_req), .flush_ack(flush_ack), .mb_stall(mb_stall),
        .mb_rdaddr0(mb_rdaddr0), .mb_rden(mb_rden), .mb_wraddr0(mb_wraddr0),
        .mb_wrdata(mb_wrdata), .mb_wren(mb_wren), .mb_rddata(mb_rddata), .mb_rden_out(mb_rden_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] mk_data(input logic [ADDR_W-1:0] a);
        logic [14*ADDR_W-1:0] w;
        w = {14{a ^ 39'h55_5555_5555}};
        return w[DATA_W-1:0];
    endfunction

    task automatic check(input string tag, input logic [CHK_W-1:0] obs, input logic [CHK_W-1:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    // memblk model: read data is valid once LAT non-stalled edges have passed since issue.
    initial begin
        int  ns;
        logic f, s, r;
        logic [ADDR_W-1:0] a;
        ns = 0;
        forever begin
            @(negedge clk);
            f = mb_rden; s = mb_stall; r = rst; a = mb_rdaddr0;
            @(posedge clk);
            if (r) begin
                mb_q.delete();
            end else if (!s) begin
                if (mb_q.size() > 0 && ns == mb_q[0].ns + LAT) void'(mb_q.pop_front());
                if (f) mb_q.push_back('{ns, a});
                ns++;
            end
            #1;
            if (mb_q.size() > 0 && ns == mb_q[0].ns + LAT) begin
                mb_rden_out = 1'b1;
                mb_rddata   = mk_data(mb_q[0].addr);
            end else begin
                mb_rden_out = 1'b0;
                mb_rddata   = '0;
            end
        end
    end

    // Scoreboard: expectations come from the driven request fields.
    always @(negedge clk) begin
        logic [ADDR_W-1:0] ea;
        exp_t e;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (mb_rden) begin
                ea = {1'b0, req_own, req_addr, req_tag};
                check("rdaddr", mb_rdaddr0, ea);
                exp_q.push_back('{req_tag, mk_data(ea)});
            end
            if (rsp_valid && rsp_ready) begin
                rsp_cnt++;
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_tag", rsp_tag, e.tag);
                    check("rsp_data", rsp_data, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load(input logic own, input logic [32:0] addr, input logic [3:0] tag);
        req_valid = 1'b1; req_we = 1'b0; req_own = own; req_addr = addr; req_tag = tag;
    endtask

    task automatic wait_rsp(input string tag, output int rc);
        bit got;
        got = 0;
        rc  = -1;
        for (int n = 0; n < LAT + 40 && !got; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1;
                rc  = cyc;
            end
        end
        if (!got) check({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int issue_cyc, rc, saw, pops, last_pop, ack_cyc, got, cnt0, f_edge;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_own = 1'b0; req_addr = '0;
        req_tag = '0; req_data = '0; rsp_ready = 1'b0; flush_req = 1'b0; mb_stall = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_flush_ack", flush_ack, 0);
        check("rst_mb_rden", mb_rden, 0);
        check("rst_mb_wren", mb_wren, 0);
        tick();
        rst = 1'b0;

        // 1: single load; latency counted in edges from the issue edge to rsp_valid.
        rsp_ready = 1'b1;
        set_load(1'b0, 33'h1_0000, 4'h3);
        @(negedge clk);
        check("t1_rden", mb_rden, 1);
        check("t1_wren", mb_wren, 0);
        issue_cyc = cyc + 1;
        tick();
        req_valid = 1'b0;
        wait_rsp("t1", rc);
        check("t1_latency", rc - issue_cyc, LAT);
        check("t1_tag", rsp_tag, 4'h3);

        // 2: eight loads consume all credits; ninth waits for a pop.
        tick();
        rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_load(i[0], 33'h200 + 33'(i), i[3:0]);
            @(negedge clk);
            check("t2_ready", req_ready, 1);
            tick();
        end
        set_load(1'b0, 33'h208, 4'h8);
        saw = 0;
        repeat (LAT + 10) begin
            @(negedge clk);
            if (req_ready || mb_rden) saw = 1;
        end
        check("t2_blocked", saw, 0);
        check("t2_fifo_valid", rsp_valid, 1);
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t2_still_blocked", req_ready, 0);
        tick();
        rsp_ready = 1'b0;
        @(negedge clk);
        check("t2_ninth_issue", mb_rden, 1);
        tick();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (LAT + 20) tick();
        check("t2_drained", exp_q.size(), 0);

        // 3: five stalled cycles stretch latency and block issue.
        set_load(1'b1, 33'h3_0000, 4'h6);
        @(negedge clk);
        check("t3_rden", mb_rden, 1);
        issue_cyc = cyc + 1;
        tick();
        req_valid = 1'b0;
        repeat (9) tick();
        mb_stall = 1'b1;
        set_load(1'b0, 33'h3_0040, 4'h7);
        saw = 0;
        repeat (5) begin
            @(negedge clk);
            if (req_ready || mb_rden) saw = 1;
            tick();
        end
        check("t3_no_issue_in_stall", saw, 0);
        mb_stall = 1'b0;
        @(negedge clk);
        check("t3_issue_after_stall", mb_rden, 1);
        tick();
        req_valid = 1'b0;
        wait_rsp("t3a", rc);
        check("t3_latency", rc - issue_cyc, LAT + 5);
        check("t3_tag_a", rsp_tag, 4'h6);
        tick();
        wait_rsp("t3b", rc);
        check("t3_tag_b", rsp_tag, 4'h7);

        // 4: store then load to the same line; only the load answers.
        tick();
        cnt0 = rsp_cnt;
        req_valid = 1'b1; req_we = 1'b1; req_own = 1'b0; req_addr = 33'h4_4444; req_tag = 4'h9;
        for (int i = 0; i < 16; i++) req_data[i*32 +: 32] = $urandom();
        req_data[DATA_W-1:512] = 21'($urandom());
        @(negedge clk);
        check("t4_wren", mb_wren, 1);
        check("t4_no_rden", mb_rden, 0);
        check("t4_wraddr", mb_wraddr0, {2'b00, 33'h4_4444, 4'h9});
        check("t4_wrdata", mb_wrdata, req_data);
        tick();
        set_load(1'b0, 33'h4_4444, 4'hA);
        @(negedge clk);
        check("t4_rden", mb_rden, 1);
        check("t4_no_wren", mb_wren, 0);
        tick();
        req_valid = 1'b0;
        repeat (LAT + 20) tick();
        check("t4_one_response", rsp_cnt - cnt0, 1);

        // 5: flush with three loads in flight.
        for (int i = 1; i <= 3; i++) begin
            set_load(1'b0, 33'h5_0000 + 33'(i), i[3:0]);
            @(negedge clk);
            check("t5_load_issue", mb_rden, 1);
            tick();
        end
        req_valid = 1'b0;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        set_load(1'b0, 33'h5_0004, 4'h4);
        got = 0; pops = 0; last_pop = -1; ack_cyc = -1; saw = 0;
        for (int n = 0; n < LAT + 30 && !got; n++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                last_pop = cyc + 1;
                pops++;
            end
            if (flush_ack) begin
                got = 1;
                ack_cyc = cyc;
            end else if (req_ready) begin
                saw = 1;
            end
        end
        check("t5_ack_seen", got, 1);
        check("t5_blocked_in_drain", saw, 0);
        check("t5_pops", pops, 3);
        check("t5_ack_after_pop", ack_cyc - last_pop, 1);
        @(negedge clk);
        check("t5_ack_pulse", flush_ack, 0);
        check("t5_resume_issue", mb_rden, 1);
        tick();
        req_valid = 1'b0;
        repeat (LAT + 20) tick();

        // 5b: flush when already empty acks two cycles after the request.
        flush_req = 1'b1;
        @(negedge clk);
        f_edge = cyc + 1;
        tick();
        flush_req = 1'b0;
        @(negedge clk);
        check("t5b_no_ack_yet", flush_ack, 0);
        @(negedge clk);
        check("t5b_ack", flush_ack, 1);
        check("t5b_ack_edge", cyc - f_edge, 1);
        tick();

        // 6: reset with loads buffered and in flight discards everything.
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_load(1'b0, 33'h6_0000 + 33'(i), 4'hB + i[3:0]);
            tick();
        end
        req_valid = 1'b0;
        repeat (LAT - 2) tick();
        @(negedge clk);
        check("t6_pre_valid", rsp_valid, 1);
        tick();
        rst = 1'b1;
        set_load(1'b0, 33'h6_0010, 4'hF);
        @(posedge clk);
        @(negedge clk);
        check("t6_rsp_valid", rsp_valid, 0);
        check("t6_req_ready", req_ready, 0);
        check("t6_flush_ack", flush_ack, 0);
        check("t6_mb_rden", mb_rden, 0);
        check("t6_mb_wren", mb_wren, 0);
        tick();
        rst = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        saw = 0;
        repeat (LAT + 20) begin
            @(negedge clk);
            if (rsp_valid) saw = 1;
        end
        check("t6_no_stale_rsp", saw, 0);
        tick();
        set_load(1'b0, 33'h7_0000, 4'h5);
        @(negedge clk);
        check("t6_recover_issue", mb_rden, 1);
        tick();
        req_valid = 1'b0;
        wait_rsp("t6", rc);
        check("t6_recover_tag", rsp_tag, 4'h5);
        tick();
        repeat (3) tick();
        check("end_scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
